// File: rtl/sram_pkg.sv
// Opcodes, address limit and FSM encoding shared by the serial SRAM port.
package sram_pkg;

  localparam logic [7:0]  OP_READ       = 8'h03;
  localparam logic [7:0]  OP_WRITE      = 8'h02;
  localparam logic [7:0]  OP_RDMR       = 8'h05;
  localparam logic [7:0]  OP_WRMR       = 8'h01;
  localparam logic [23:0] SRAM_MAX_ADDR = 24'h1FFFF;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD} state_t;

  function automatic logic op_supported(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_RDMR) || (op == OP_WRMR);
  endfunction

  // Mode-register opcodes carry no address and exactly one data byte.
  function automatic logic op_is_mode(input logic [7:0] op);
    return (op == OP_RDMR) || (op == OP_WRMR);
  endfunction

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_WRMR);
  endfunction

endpackage

// File: rtl/sram_spi_port_if.sv
// Task-manager command/bit-stream signals plus SRAM pins for one serial SRAM.
// Optional SRAM_BYTE_OUT_EN adds rd_byte/rd_byte_valid.
interface sram_spi_port_if;
  // start is a one-cycle strobe honoured only while busy is low. input_valid and
  // output_valid are one-cycle strobes with no backpressure: write_in must be
  // valid in the input_valid cycle, so is valid in the output_valid cycle.
  logic        start;
  logic [7:0]  sram_inst;
  logic [23:0] address;
  logic [23:0] length;
  logic        write_in;
  logic        input_valid;
  logic        so;
  logic        output_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic        sram_cs_n;
  logic        sram_sck;
  logic        sram_si;
  logic        sram_so;
`ifdef SRAM_BYTE_OUT_EN
  logic [7:0]  rd_byte;
  logic        rd_byte_valid;

  modport slave (
    input  start, sram_inst, address, length, write_in, sram_so,
    output input_valid, so, output_valid, busy, done, err,
           sram_cs_n, sram_sck, sram_si, rd_byte, rd_byte_valid
  );
  modport master (
    output start, sram_inst, address, length, write_in, sram_so,
    input  input_valid, so, output_valid, busy, done, err,
           sram_cs_n, sram_sck, sram_si, rd_byte, rd_byte_valid
  );
`else
  modport slave (
    input  start, sram_inst, address, length, write_in, sram_so,
    output input_valid, so, output_valid, busy, done, err,
           sram_cs_n, sram_sck, sram_si
  );
  modport master (
    output start, sram_inst, address, length, write_in, sram_so,
    input  input_valid, so, output_valid, busy, done, err,
           sram_cs_n, sram_sck, sram_si
  );
`endif
endinterface

// File: rtl/sram_spi_port_spi_clk_gen.sv
// SCK divider: o_sck toggles every CLK_DIV enabled cycles; strobes mark its edges.
// rise/fall strobes coincide with the first cycle of the new SCK level.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_stb,
  output logic o_fall_stb,
  output logic o_pre_fall_stb,
  output logic o_pre_rise_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sck;
  logic             r_rise;
  logic             r_fall;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sck  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sck  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sck  <= ~r_sck;
      r_rise <= ~r_sck;
      r_fall <= r_sck;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  // Look-ahead strobes are not gated by i_en so the caller may use them to drop i_en.
  assign o_sck          = r_sck;
  assign o_rise_stb     = r_rise;
  assign o_fall_stb     = r_fall;
  assign o_pre_fall_stb = w_wrap & r_sck;
  assign o_pre_rise_stb = w_wrap & ~r_sck;

endmodule

// File: rtl/sram_spi_port.sv
// SPI mode-0 master for one 23LC1024-class SRAM: command, address, bit-serial data.
// Build option SRAM_BYTE_OUT_EN assembles read bits into rd_byte.
module sram_spi_port
  import sram_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_spi_port_if.slave   bus,
  output state_t           o_state
);

  localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

  state_t              r_state, w_next;
  logic                r_cs_n, r_si, r_so, r_ov, r_done, r_err;
  logic                r_is_write, r_is_mode, r_done_bits, r_tail;
  logic [7:0]          r_sh;
  logic [23:0]         r_addr, r_len;
  logic [2:0]          r_bit;
  logic [1:0]          r_ab;
  logic [HOLD_W-1:0]   r_hold;

  logic w_sck, w_rise, w_fall, w_pre_fall, w_pre_rise;
  logic w_cmd_ok, w_accept, w_reject, w_adv, w_byte_end, w_last_data_bit;
  logic w_next_wr, w_iv, w_end, w_sample;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (~r_cs_n & ~w_end),
    .o_sck          (w_sck),
    .o_rise_stb     (w_rise),
    .o_fall_stb     (w_fall),
    .o_pre_fall_stb (w_pre_fall),
    .o_pre_rise_stb (w_pre_rise)
  );

  assign w_cmd_ok = op_supported(bus.sram_inst) &&
                    (op_is_mode(bus.sram_inst) ||
                     ((bus.address <= SRAM_MAX_ADDR) && (bus.length != 24'd0)));
  assign w_accept = (r_state == IDLE) && bus.start && w_cmd_ok;
  assign w_reject = (r_state == IDLE) && bus.start && !w_cmd_ok;

  // A bit finishes in the cycle before SCK falls; the next bit goes out with the fall.
  assign w_adv           = w_pre_fall && !r_done_bits &&
                           ((r_state == CMD) || (r_state == ADDR) || (r_state == DATA));
  assign w_byte_end      = w_adv && (r_bit == 3'd7);
  assign w_last_data_bit = (r_state == DATA) && (r_bit == 3'd7) && (r_len == 24'd1);
  assign w_next_wr       = r_is_write &&
                           (((r_state == CMD) && (r_bit == 3'd7) && r_is_mode) ||
                            ((r_state == ADDR) && (r_bit == 3'd7) && (r_ab == 2'd2)) ||
                            ((r_state == DATA) && !w_last_data_bit));
  assign w_iv            = w_adv && w_next_wr;
  assign w_sample        = (r_state == DATA) && !r_is_write && w_rise;
  // The transaction closes where the next SCK rise would have been.
  assign w_end           = (r_state == DATA) && w_pre_rise &&
                           (r_tail || (w_fall && r_done_bits));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = CMD;
      CMD:  if (w_byte_end) w_next = r_is_mode ? DATA : ADDR;
      ADDR: if (w_byte_end && (r_ab == 2'd2)) w_next = DATA;
      DATA: if (w_end) w_next = (CS_HOLD == 0) ? IDLE : HOLD;
      HOLD: if (r_hold == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_n      <= 1'b1;
      r_si        <= 1'b0;
      r_so        <= 1'b0;
      r_ov        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_is_write  <= 1'b0;
      r_is_mode   <= 1'b0;
      r_done_bits <= 1'b0;
      r_tail      <= 1'b0;
      r_sh        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_bit       <= '0;
      r_ab        <= '0;
      r_hold      <= '0;
    end else begin
      r_ov   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= w_reject;
      if (w_accept) begin
        r_cs_n      <= 1'b0;
        r_si        <= bus.sram_inst[7];
        r_sh        <= {bus.sram_inst[6:0], 1'b0};
        r_addr      <= bus.address;
        r_len       <= op_is_mode(bus.sram_inst) ? 24'd1 : bus.length;
        r_is_write  <= op_is_write(bus.sram_inst);
        r_is_mode   <= op_is_mode(bus.sram_inst);
        r_bit       <= '0;
        r_ab        <= '0;
        r_done_bits <= 1'b0;
        r_tail      <= 1'b0;
      end
      if (w_adv) begin
        r_bit <= r_bit + 3'd1;
        case (r_state)
          CMD: begin
            if (r_bit != 3'd7) begin
              r_si <= r_sh[7];
              r_sh <= {r_sh[6:0], 1'b0};
            end else if (r_is_mode) begin
              r_si <= w_iv & bus.write_in;
            end else begin
              r_si   <= r_addr[23];
              r_addr <= {r_addr[22:0], 1'b0};
            end
          end
          ADDR: begin
            if ((r_bit == 3'd7) && (r_ab == 2'd2)) begin
              r_si <= w_iv & bus.write_in;
            end else begin
              r_si   <= r_addr[23];
              r_addr <= {r_addr[22:0], 1'b0};
            end
            if (r_bit == 3'd7) r_ab <= r_ab + 2'd1;
          end
          DATA: begin
            r_si <= w_iv & bus.write_in;
            if (r_bit == 3'd7) begin
              r_len <= r_len - 24'd1;
              if (r_len == 24'd1) r_done_bits <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (w_sample) begin
        r_so <= bus.sram_so;
        r_ov <= 1'b1;
      end
      if ((r_state == DATA) && w_fall && r_done_bits) r_tail <= 1'b1;
      if (w_end) begin
        r_cs_n <= 1'b1;
        r_done <= 1'b1;
        r_tail <= 1'b0;
        r_si   <= 1'b0;
        r_hold <= HOLD_W'(CS_HOLD - 1);
      end
      if ((r_state == HOLD) && (r_hold != '0)) r_hold <= r_hold - HOLD_W'(1);
    end
  end

`ifdef SRAM_BYTE_OUT_EN
  logic [6:0] r_rd_sh;
  logic [7:0] r_rd_byte;
  logic       r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sh    <= '0;
      r_rd_byte  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_sample) begin
        r_rd_sh <= {r_rd_sh[5:0], bus.sram_so};
        if (r_bit == 3'd7) begin
          r_rd_byte  <= {r_rd_sh, bus.sram_so};
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_byte       = r_rd_byte;
  assign bus.rd_byte_valid = r_rd_valid;
`endif

  assign bus.input_valid  = w_iv;
  assign bus.so           = r_so;
  assign bus.output_valid = r_ov;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.sram_cs_n    = r_cs_n;
  assign bus.sram_sck     = w_sck;
  assign bus.sram_si      = r_si;
  assign o_state          = r_state;

endmodule

// File: tb/tb_sram_spi_port.sv
// Directed bench for sram_spi_port with a bit-level SRAM model on the pins.
// Covers SRAM_BYTE_OUT_EN when the macro is defined for the build.
module tb_sram_spi_port;
  import sram_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dut_state;

  sram_spi_port_if bus();

  sram_spi_port #(.CLK_DIV(2), .CS_HOLD(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dut_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          rise_cnt = 0, iv_cnt = 0, ov_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [63:0] si_bits = '0;
  logic [15:0] so_bits = '0;
  logic        prev_sck = 1'b0;
  logic [7:0]  wr_pattern = '0;
  logic [15:0] rd_pattern = '0;
  int          hdr_bits = 0, rd_nbits = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  function automatic logic so_bit(input int n);
    int k;
    k = n - hdr_bits;
    if (k >= 0 && k < rd_nbits) return rd_pattern[rd_nbits - 1 - k];
    return 1'b0;
  endfunction

  // Pin-level monitor and SRAM/write-data model, all sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.sram_sck && !prev_sck) begin
      rise_cnt++;
      si_bits = {si_bits[62:0], bus.sram_si};
    end
    prev_sck = bus.sram_sck;
    bus.write_in = wr_pattern[3'(7 - (iv_cnt % 8))];
    if (bus.input_valid) iv_cnt++;
    if (bus.output_valid) begin
      ov_cnt++;
      so_bits = {so_bits[14:0], bus.so};
    end
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (!bus.sram_sck) bus.sram_so = so_bit(rise_cnt);
`ifdef SRAM_BYTE_OUT_EN
    if (bus.rd_byte_valid) got_q.push_back(bus.rd_byte);
`endif
  end

  task automatic clear_mon();
    rise_cnt = 0; iv_cnt = 0; ov_cnt = 0; done_cnt = 0; err_cnt = 0;
    si_bits = '0; so_bits = '0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic issue(input logic [7:0] op, input logic [23:0] addr, input logic [23:0] len);
    @(negedge clk);
    bus.start = 1'b1; bus.sram_inst = op; bus.address = addr; bus.length = len;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, bus.busy, budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sram_cs_n, bus.sram_sck, bus.busy, bus.done, bus.err, bus.input_valid,
         bus.output_valid, bus.sram_si} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got cs,sck,busy,done,err,iv,ov,si=%b required 10000000",
               {bus.sram_cs_n, bus.sram_sck, bus.busy, bus.done, bus.err, bus.input_valid,
                bus.output_valid, bus.sram_si});
    end
    checks++;
    if (dut_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dut_state, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit found;
    int n;
    clear_mon();
    wr_pattern = 8'hA5;
    issue(8'h02, 24'h000010, 24'd1);
    checks++;
    if ({bus.sram_cs_n, bus.busy, bus.sram_si} !== 3'b010) begin
      errors++;
      $display("FAIL write_start: got cs,busy,si=%b required 010", {bus.sram_cs_n, bus.busy, bus.sram_si});
    end
    repeat (30) @(negedge clk);
    bus.start = 1'b1; bus.sram_inst = 8'h07;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.done) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL write_done_seen: got %b required 1", found);
    end
    checks++;
    if (bus.sram_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL write_cs_at_done: got %b required 1", bus.sram_cs_n);
    end
    n = 0;
    while (bus.busy && n < 10) begin n++; @(negedge clk); end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL write_hold_cycles: got %0d required 2", n);
    end
    @(negedge clk);
    checks++;
    if (si_bits[39:0] !== 40'h02_000010_A5) begin
      errors++;
      $display("FAIL write_si_stream: got %h required 02000010a5", si_bits[39:0]);
    end
    checks++;
    if (rise_cnt !== 40) begin
      errors++;
      $display("FAIL write_sck_rises: got %0d required 40", rise_cnt);
    end
    checks++;
    if (iv_cnt !== 8) begin
      errors++;
      $display("FAIL write_input_valid: got %0d required 8", iv_cnt);
    end
    checks++;
    if ({done_cnt, err_cnt, ov_cnt} !== {32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL write_strobes: got done=%0d err=%0d ov=%0d required 1 0 0", done_cnt, err_cnt, ov_cnt);
    end
  endtask

  task automatic test_read();
    clear_mon();
    hdr_bits = 32; rd_nbits = 16; rd_pattern = 16'h3CC3;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    issue(8'h03, 24'h01FFFF, 24'd2);
    wait_idle("read", 3000);
    checks++;
    if (rise_cnt !== 48) begin
      errors++;
      $display("FAIL read_sck_rises: got %0d required 48", rise_cnt);
    end
    checks++;
    if (si_bits[47:0] !== 48'h0301FFFF_0000) begin
      errors++;
      $display("FAIL read_si_stream: got %h required 0301ffff0000", si_bits[47:0]);
    end
    checks++;
    if ({ov_cnt, done_cnt, iv_cnt} !== {32'd16, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL read_strobes: got ov=%0d done=%0d iv=%0d required 16 1 0", ov_cnt, done_cnt, iv_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = so_bits[15 - 8 * i -: 8];
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL read_so_byte%0d: got %h required %h", i, g, e);
      end
`ifdef SRAM_BYTE_OUT_EN
      checks++;
      if (got_q.size() <= i || got_q[i] !== e) begin
        errors++;
        $display("FAIL read_rd_byte%0d: got %h (count %0d) required %h", i,
                 (got_q.size() > i) ? got_q[i] : 8'hxx, got_q.size(), e);
      end
`endif
    end
  endtask

  task automatic test_rdmr();
    clear_mon();
    hdr_bits = 8; rd_nbits = 8; rd_pattern = 16'h0040;
    issue(8'h05, 24'h000000, 24'd0);
    wait_idle("rdmr", 2000);
    checks++;
    if ({rise_cnt, ov_cnt, done_cnt} !== {32'd16, 32'd8, 32'd1}) begin
      errors++;
      $display("FAIL rdmr_counts: got rises=%0d ov=%0d done=%0d required 16 8 1", rise_cnt, ov_cnt, done_cnt);
    end
    checks++;
    if ({si_bits[15:8], so_bits[7:0]} !== 16'h0540) begin
      errors++;
      $display("FAIL rdmr_bytes: got si=%h so=%h required 05 40", si_bits[15:8], so_bits[7:0]);
    end
`ifdef SRAM_BYTE_OUT_EN
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h40) begin
      errors++;
      $display("FAIL rdmr_rd_byte: got count %0d required one byte 40", got_q.size());
    end
`endif
  endtask

  task automatic test_reject();
    logic [7:0]  ops[4]   = '{8'h07, 8'h03, 8'h03, 8'h02};
    logic [23:0] addrs[4] = '{24'h000000, 24'h020000, 24'h000010, 24'h000010};
    logic [23:0] lens[4]  = '{24'd1, 24'd1, 24'd0, 24'd0};
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      issue(ops[v], addrs[v], lens[v]);
      checks++;
      if ({bus.err, bus.sram_cs_n, bus.busy} !== 3'b110) begin
        errors++;
        $display("FAIL reject%0d_pulse: got err,cs,busy=%b required 110", v,
                 {bus.err, bus.sram_cs_n, bus.busy});
      end
      repeat (10) @(negedge clk);
      checks++;
      if ({err_cnt, rise_cnt, done_cnt} !== {32'd1, 32'd0, 32'd0}) begin
        errors++;
        $display("FAIL reject%0d_quiet: got err=%0d rises=%0d done=%0d required 1 0 0", v,
                 err_cnt, rise_cnt, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    wr_pattern = 8'hFF;
    issue(8'h02, 24'h000040, 24'd2);
    for (int i = 0; i < 1000; i++) begin
      if (rise_cnt >= 20) break;
      @(negedge clk);
    end
    checks++;
    if (rise_cnt < 20) begin
      errors++;
      $display("FAIL abort_reach: got %0d rises required 20", rise_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sram_cs_n, bus.sram_sck, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL abort_pins: got cs,sck,busy=%b required 100", {bus.sram_cs_n, bus.sram_sck, bus.busy});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d required 0", done_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    wr_pattern = 8'h5A;
    issue(8'h02, 24'h000123, 24'd1);
    wait_idle("after_abort", 2000);
    checks++;
    if (si_bits[39:0] !== 40'h02_000123_5A) begin
      errors++;
      $display("FAIL after_abort_stream: got %h required 020001235a", si_bits[39:0]);
    end
    checks++;
    if ({done_cnt, iv_cnt, rise_cnt} !== {32'd1, 32'd8, 32'd40}) begin
      errors++;
      $display("FAIL after_abort_counts: got done=%0d iv=%0d rises=%0d required 1 8 40",
               done_cnt, iv_cnt, rise_cnt);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.sram_inst = '0; bus.address = '0; bus.length = '0;
    bus.write_in = 1'b0; bus.sram_so = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_rdmr();
    test_reject();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sram_spi_port.md
Name: sram_spi_port

Overview:
- Per-chip SPI master for one 23LC1024-class serial SRAM (128 KiB, max address 0x1FFFF).
- Sits between the task manager and the SRAM pins; the accelerator instantiates four, one per SRAM.
- Accepts one opcode/address/length command, runs the full SPI mode-0 transaction, and streams data bits both ways.
- Serial write data is requested bit-by-bit from the task manager; read data is returned bit-by-bit with a valid strobe.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles (>=1); one SPI bit takes 2*CLK_DIV clk cycles.
- CS_HOLD, 2: clk cycles cs_n stays high after a transaction before a new start is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  command strobe, sampled in IDLE only.
- sram_inst  in  8  opcode: 0x03 READ, 0x02 WRITE, 0x05 RDMR, 0x01 WRMR.
- address  in  24  byte address.
- length  in  24  data byte count.
- write_in  in  1  serial write data bit, sampled while input_valid=1.
- input_valid  out  1  one-cycle request/sample strobe for write_in.
- so  out  1  last sampled read data bit.
- output_valid  out  1  one-cycle strobe: so is newly updated.
- busy  out  1  transaction in progress (includes CS_HOLD).
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  one-cycle pulse when a start is rejected.
- sram_cs_n  out  1  chip select to the SRAM.
- sram_sck  out  1  SPI clock to the SRAM.
- sram_si  out  1  MOSI to the SRAM.
- sram_so  in  1  MISO from the SRAM.

Behaviour:
- Reset values: sram_cs_n=1; all other outputs 0; state IDLE.
- Asserting rst_n low mid-transaction aborts immediately with no done pulse.
- States and transitions: IDLE -> CMD (8 bits) -> ADDR (24 bits; skipped for RDMR/WRMR) -> DATA -> HOLD -> IDLE.
- Start acceptance, in IDLE only:
  - Reject (err pulse, no pin activity, stay in IDLE) if: opcode unsupported; address > 0x1FFFF for READ/WRITE; or length == 0 for READ/WRITE.
  - Otherwise latch opcode, address and length. RDMR/WRMR force length to 1.
- start while busy: ignored, no err.
- Start timing: cycle after acceptance, sram_cs_n=0, busy=1, and sram_si holds opcode bit 7.
- Bit timing:
  - SCK rises CLK_DIV cycles after the bit is driven, then falls CLK_DIV cycles later.
  - Bits are sent MSB first. The next bit is driven on the falling edge.
  - sram_sck idles at 0.
- DATA phase, write (WRITE, WRMR):
  - input_valid pulses in the clk cycle before each SCK falling edge that starts a data bit; write_in is captured in that same cycle.
  - 8*length pulses in total; sram_si is undriven (0) after the last bit.
- DATA phase, read (READ, RDMR):
  - sram_so is sampled at each SCK rising edge.
  - so updates and output_valid pulses on the following cycle.
  - sram_si=0 during the read data phase.
- End of transaction:
  - CLK_DIV cycles after the last falling edge: sram_cs_n=1 and done pulses.
  - busy stays 1 for CS_HOLD further cycles, then IDLE.
- Counters and widths:
  - Bit counter is 3 bits; byte counter is 24 bits and decrements at the end of each data byte. Length 0xFFFFFF must be handled.
  - Address wrap past 0x1FFFF is the device's sequential-mode behaviour; the controller only counts bytes.

Optional Feature:
- Macro: SRAM_BYTE_OUT_EN.
- Defined: adds ports rd_byte (out, 8) and rd_byte_valid (out, 1). rd_byte_valid pulses together with the 8th output_valid of each read byte, with the assembled byte MSB-first.
- Undefined: those ports and the shift register are absent. Bit behaviour is unchanged.

Decomposition:
- Package sram_pkg holds:
  - opcode localparams (OP_READ, OP_WRITE, OP_RDMR, OP_WRMR);
  - SRAM_MAX_ADDR = 24'h1FFFF;
  - state enum state_t {IDLE, CMD, ADDR, DATA, HOLD}.
- One sub-module, spi_clk_gen: divider counter producing the rise_stb, fall_stb and pre_fall_stb phase strobes, enabled while cs_n is low.

Test Plan:
- Reset: hold rst_n=0 -> sram_cs_n=1, sram_sck=0, busy/done/err/input_valid/output_valid=0.
- WRITE 0x02, addr 0x000010, len 1, write_in pattern 0xA5 -> SI stream 02 00 00 10 A5, 40 SCK rises, 8 input_valid pulses, one done, cs_n high after.
- READ 0x03, addr 0x01FFFF, len 2, SRAM model returns 0x3C 0xC3 -> 16 output_valid pulses carrying those bits. With SRAM_BYTE_OUT_EN: rd_byte 0x3C then 0xC3.
- RDMR 0x05 with len 0 -> 16 SCK rises (no address phase), 8 output_valid pulses, mode byte returned.
- Rejects: opcode 0x07, addr 0x020000, or READ len 0 -> err pulse, sram_cs_n stays 1, busy stays 0.
- rst_n low after 20 SCK rises -> cs_n=1 and sck=0 immediately, no done pulse. A following WRITE completes correctly.
